fp_sqrt_prenorm: RTL and testbench

FP_SQRT_PRENORM -- requirements
Module: fp_sqrt_prenorm

---
 rtl/fp_sqrt_pkg.sv | 19 +
 rtl/fp_lod.sv | 17 +
 rtl/fp_sqrt_prenorm.sv | 102 ++++++++++
 tb/tb_fp_sqrt_prenorm.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared width helpers for the fixed-point square-root path (prenorm and core).
// The mantissa is unsigned 2.(WL-2); the half-exponent is signed clog2(WL)+1 bits.
package fp_sqrt_pkg;

    localparam int MANT_INT_BITS = 2;

    function automatic int calc_ew(input int wl);
        return $clog2(wl) + 1;
    endfunction

    function automatic int calc_pw(input int wl);
        return $clog2(wl);
    endfunction

    function automatic int mant_frac_bits(input int wl);
        return wl - MANT_INT_BITS;
    endfunction

endpackage

// File: rtl/fp_lod.sv
// Leading-one detector: position of the highest set bit of vec (0 when vec is 0).
module fp_lod #(
    parameter int N  = 7,
    parameter int PW = 3
) (
    input  logic [N-1:0]  vec,
    output logic [PW-1:0] pos
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) pos = PW'(i);
        end
    end

endmodule

// File: rtl/fp_sqrt_prenorm.sv
// Square-root pre-normalizer: din = mant * 4^exp_half with mant in [1,4).
// Three CE-gated stages: capture/classify, leading-one, shift/exponent.
module fp_sqrt_prenorm
    import fp_sqrt_pkg::*;
#(
    parameter int WI           = 4,
    parameter int WF           = 4,
    parameter int LUT_addWidth = 4,
    localparam int WL          = WI + WF,
    localparam int EW          = calc_ew(WL)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    CE,
    input  logic [WL-1:0]           din,
    input  logic                    din_valid,
    output logic [WL-1:0]           mant,
    output logic [EW-1:0]           exp_half,
    output logic [LUT_addWidth-1:0] lut_addr,
    output logic                    dout_valid,
    output logic                    zero,
    output logic                    neg
);

    localparam int PW = calc_pw(WL);

    // stage 1
    logic          v1, neg1, zero1;
    logic [WL-1:0] d1;
    // stage 2
    logic          v2, neg2, zero2;
    logic [WL-1:0] d2;
    logic [PW-1:0] p2;
    logic [PW-1:0] p1;

    fp_lod #(.N(WL-1), .PW(PW)) u_lod (
        .vec (d1[WL-2:0]),
        .pos (p1)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v1    <= 1'b0;
            d1    <= '0;
            neg1  <= 1'b0;
            zero1 <= 1'b0;
            v2    <= 1'b0;
            d2    <= '0;
            neg2  <= 1'b0;
            zero2 <= 1'b0;
            p2    <= '0;
        end else if (CE) begin
            v1    <= din_valid;
            d1    <= din;
            neg1  <= din[WL-1];
            zero1 <= (din == '0);
            v2    <= v1;
            d2    <= d1;
            neg2  <= neg1;
            zero2 <= zero1;
            p2    <= p1;
        end
    end

    // Odd e shifts one further so the leading one lands in the upper integer bit.
    logic signed [EW:0] e;
    logic [PW:0]        sh;
    logic [WL-1:0]      mant_n;
    logic [EW-1:0]      exp_n;

    always_comb begin
        e      = (EW+1)'(p2) - (EW+1)'(WF);
        sh     = e[0] ? ((PW+1)'(WL-1) - {1'b0, p2}) : ((PW+1)'(WL-2) - {1'b0, p2});
        mant_n = d2 << sh;
        exp_n  = e[EW:1];
        if (neg2 || zero2) begin
            mant_n = '0;
            exp_n  = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dout_valid <= 1'b0;
            mant       <= '0;
            exp_half   <= '0;
            lut_addr   <= '0;
            zero       <= 1'b0;
            neg        <= 1'b0;
        end else if (CE) begin
            dout_valid <= v2;
            if (v2) begin
                mant     <= mant_n;
                exp_half <= exp_n;
                lut_addr <= mant_n[WL-2 -: LUT_addWidth];
                zero     <= zero2;
                neg      <= neg2;
            end
        end
    end

endmodule

// File: tb/tb_fp_sqrt_prenorm.sv
// Scoreboard bench for fp_sqrt_prenorm (WI=4, WF=4): directed vectors, CE stalls, mid-flight reset.
module tb_fp_sqrt_prenorm;

    logic       CLK, nRST, CE, din_valid;
    logic [7:0] din;
    logic [7:0] mant;
    logic [3:0] exp_half;
    logic [3:0] lut_addr;
    logic       dout_valid, zero, neg;

    fp_sqrt_prenorm dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .CE         (CE),
        .din        (din),
        .din_valid  (din_valid),
        .mant       (mant),
        .exp_half   (exp_half),
        .lut_addr   (lut_addr),
        .dout_valid (dout_valid),
        .zero       (zero),
        .neg        (neg)
    );

    typedef struct packed {
        logic [7:0]  mant;
        logic [3:0]  exp;
        logic [3:0]  lut;
        logic        zero;
        logic        neg;
        logic [31:0] issue;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned ecnt  = 0;
    logic        ce_seen = 1'b0;
    logic [7:0]  last_mant = '0;
    logic [3:0]  last_exp = '0, last_lut = '0;
    logic        last_zero = 1'b0, last_neg = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Enabled-cycle counter gives the latency reference.
    always @(posedge CLK) begin
        if (CE && nRST) ecnt <= ecnt + 1;
        ce_seen <= CE && nRST;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: only look after an edge that actually advanced the pipeline.
    always @(negedge CLK) begin
        if (nRST && ce_seen) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'd0, dout_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mant", {24'd0, mant}, {24'd0, e.mant});
                    chk("exp_half", {28'd0, exp_half}, {28'd0, e.exp});
                    chk("lut_addr", {28'd0, lut_addr}, {28'd0, e.lut});
                    chk("zero", {31'd0, zero}, {31'd0, e.zero});
                    chk("neg", {31'd0, neg}, {31'd0, e.neg});
                    chk("latency", ecnt, e.issue + 3);
                end
                last_mant = mant; last_exp = exp_half; last_lut = lut_addr;
                last_zero = zero; last_neg = neg;
            end else begin
                chk("hold_mant", {24'd0, mant}, {24'd0, last_mant});
                chk("hold_exp", {28'd0, exp_half}, {28'd0, last_exp});
                chk("hold_flags", {28'd0, lut_addr, zero, neg}, {28'd0, last_lut, last_zero, last_neg});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] m, input logic [3:0] e,
                        input logic [3:0] l, input logic z, input logic n);
        exp_t x;
        x.mant = m; x.exp = e; x.lut = l; x.zero = z; x.neg = n; x.issue = ecnt;
        exp_q.push_back(x);
        din = d;
        din_valid = 1'b1;
        @(posedge CLK); #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_mant"}, {24'd0, mant}, 32'd0);
        chk({tag, "_exp_lut"}, {24'd0, exp_half, lut_addr}, 32'd0);
        chk({tag, "_flags"}, {30'd0, zero, neg}, 32'd0);
    endtask

    initial begin
        nRST = 1'b1; CE = 1'b1; din = '0; din_valid = 1'b0;
        #1 nRST = 1'b0;
        #3 chk_cleared("reset");
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // din, mant, exp_half, lut_addr, zero, neg
        send(8'h18, 8'h60, 4'h0, 4'b1100, 1'b0, 1'b0);   // 1.5
        send(8'h3C, 8'hF0, 4'h0, 4'b1110, 1'b0, 1'b0);   // 3.75
        send(8'h7F, 8'h7F, 4'h1, 4'b1111, 1'b0, 1'b0);   // 7.9375
        idle(1);
        send(8'h01, 8'h40, 4'hE, 4'b1000, 1'b0, 1'b0);   // 1/16
        send(8'h03, 8'hC0, 4'hE, 4'b1000, 1'b0, 1'b0);   // 3/16
        send(8'h00, 8'h00, 4'h0, 4'b0000, 1'b1, 1'b0);   // zero
        send(8'h81, 8'h00, 4'h0, 4'b0000, 1'b0, 1'b1);   // negative
        idle(4);

        // Five back-to-back samples with a 2-cycle CE drop; din is junk while stalled.
        send(8'h10, 8'h40, 4'h0, 4'b1000, 1'b0, 1'b0);   // 1.0
        send(8'h20, 8'h80, 4'h0, 4'b0000, 1'b0, 1'b0);   // 2.0
        send(8'h40, 8'h40, 4'h1, 4'b1000, 1'b0, 1'b0);   // 4.0
        CE = 1'b0; din = 8'h55; din_valid = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        CE = 1'b1; din_valid = 1'b0;
        send(8'h02, 8'h80, 4'hE, 4'b0000, 1'b0, 1'b0);   // 0.125
        send(8'h0C, 8'hC0, 4'hF, 4'b1000, 1'b0, 1'b0);   // 0.75
        idle(5);

        // Reset with three samples in flight: everything discarded.
        send(8'h18, 8'h60, 4'h0, 4'b1100, 1'b0, 1'b0);
        send(8'h3C, 8'hF0, 4'h0, 4'b1110, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 4'h0, 4'b0000, 1'b0, 1'b1);
        nRST = 1'b0;
        exp_q.delete();
        last_mant = '0; last_exp = '0; last_lut = '0; last_zero = 1'b0; last_neg = 1'b0;
        #1 chk_cleared("midreset");
        repeat (2) begin @(posedge CLK); #1; end
        nRST = 1'b1;
        idle(6);

        // First sample after release appears three enabled cycles later.
        send(8'h7F, 8'h7F, 4'h1, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        chk("drain", exp_q.size(), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
